// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection: light codes, sequencer states and
// the light-pair decode used by the sequencer and its wrappers.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [LIGHT_W-1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_RED    = 2'b10
  } light_t;

  typedef enum logic [STATE_W-1:0] {
    S_A_GRN  = 3'd0,
    S_A_YEL  = 3'd1,
    S_AB_RED = 3'd2,
    S_B_GRN  = 3'd3,
    S_B_YEL  = 3'd4,
    S_BA_RED = 3'd5
  } state_t;

  typedef struct packed {
    light_t la;
    light_t lb;
  } lights_t;

  // Signal-head pair shown in each state; anything unlisted is all-red.
  function automatic lights_t decode_lights(input state_t s);
    lights_t l;
    l.la = LIGHT_RED;
    l.lb = LIGHT_RED;
    case (s)
      S_A_GRN: l.la = LIGHT_GREEN;
      S_A_YEL: l.la = LIGHT_YELLOW;
      S_B_GRN: l.lb = LIGHT_GREEN;
      S_B_YEL: l.lb = LIGHT_YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase timer for the traffic sequencer: clears on a state change, otherwise
// counts up and holds once it reaches the supplied limit.
module tl_phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic [TW-1:0] i_limit,
  output logic [TW-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (o_cnt != i_limit) begin
      o_cnt <= o_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer (Moore FSM + shared phase timer).
// Define TRAFFIC_ALL_RED_EN to insert all-red clearance after each yellow.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN_CYC = 4,
  parameter int unsigned YELLOW_CYC    = 5,
  parameter int unsigned ALLRED_CYC    = 2,
  parameter int unsigned TW            = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_TA,
  input  logic               i_TB,
  input  logic               i_M,
  output logic [LIGHT_W-1:0] o_LA,
  output logic [LIGHT_W-1:0] o_LB,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned MAX_HOLD_A = (MIN_GREEN_CYC > YELLOW_CYC) ? MIN_GREEN_CYC : YELLOW_CYC;
  localparam int unsigned MAX_HOLD   = (MAX_HOLD_A > ALLRED_CYC) ? MAX_HOLD_A : ALLRED_CYC;

  // Reject configurations the timer cannot represent.
  if (MIN_GREEN_CYC == 0 || YELLOW_CYC == 0 || ALLRED_CYC == 0) begin : g_bad_durations
    $error("traffic_light_ctrl: phase durations must be at least 1 cycle");
  end
  if (MAX_HOLD > (2 ** TW)) begin : g_bad_tw
    $error("traffic_light_ctrl: TW too narrow for longest phase");
  end

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] cnt;
  logic [TW-1:0] limit;
  logic          clr;
  logic          green_done;
  logic          yel_done;
  lights_t       lights_nx;

  tl_phase_timer #(.TW(TW)) u_timer (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clr   (clr),
    .i_limit (limit),
    .o_cnt   (cnt)
  );

  assign green_done = (cnt == TW'(MIN_GREEN_CYC - 1));
  assign yel_done   = (cnt == TW'(YELLOW_CYC - 1));
  assign clr        = (state_nx != state);
  assign lights_nx  = decode_lights(state_nx);
  assign o_state    = state;

  // Per-state hold limit for the timer.
  always_comb begin
    limit = '0;
    case (state)
      S_A_GRN, S_B_GRN: limit = TW'(MIN_GREEN_CYC - 1);
      S_A_YEL, S_B_YEL: limit = TW'(YELLOW_CYC - 1);
`ifdef TRAFFIC_ALL_RED_EN
      S_AB_RED, S_BA_RED: limit = TW'(ALLRED_CYC - 1);
`endif
      default: limit = '0;
    endcase
  end

  // Next-state: sensors and parade only matter in green phases.
  always_comb begin
    state_nx = state;
    case (state)
      S_A_GRN: if (green_done && (!i_TA || i_M)) state_nx = S_A_YEL;
`ifdef TRAFFIC_ALL_RED_EN
      S_A_YEL:  if (yel_done) state_nx = S_AB_RED;
      S_AB_RED: if (cnt == TW'(ALLRED_CYC - 1)) state_nx = S_B_GRN;
`else
      S_A_YEL:  if (yel_done) state_nx = S_B_GRN;
`endif
      S_B_GRN: if (green_done && !i_TB && !i_M) state_nx = S_B_YEL;
`ifdef TRAFFIC_ALL_RED_EN
      S_B_YEL:  if (yel_done) state_nx = S_BA_RED;
      S_BA_RED: if (cnt == TW'(ALLRED_CYC - 1)) state_nx = S_A_GRN;
`else
      S_B_YEL:  if (yel_done) state_nx = S_A_GRN;
`endif
      default: state_nx = S_A_GRN;
    endcase
  end

  // Lights are registered from the next state so they track the state register exactly.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_A_GRN;
      o_LA  <= LIGHT_GREEN;
      o_LB  <= LIGHT_RED;
    end else begin
      state <= state_nx;
      o_LA  <= lights_nx.la;
      o_LB  <= lights_nx.lb;
    end
  end

endmodule
